// File: rtl/pc_redirect_unit_if.sv
// pc_redirect_unit_if: fetch request bundle between the PC unit
// (master) and the instruction memory port (slave).
interface pc_redirect_unit_if;
    logic [31:0] pc_f;
    logic [31:0] pc8_f;
    logic        if_req;
    logic        if_ready;
    logic        redirect;

    modport master (
        output pc_f, pc8_f, if_req, redirect,
        input  if_ready
    );

    modport slave (
        input  pc_f, pc8_f, if_req, redirect,
        output if_ready
    );
endinterface

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC register applying D-stage branch/jump redirects.
// Define PC_REDIRECT_EXC_EN to add the exc_req port (jump to EXC_VEC).
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_en,
    input  logic        br_taken,
    input  logic [31:0] pc_d,
    input  logic [15:0] imm16_d,
    input  logic        j_en,
    input  logic [25:0] j_index,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
`ifdef PC_REDIRECT_EXC_EN
    input  logic        exc_req,
`endif
    pc_redirect_unit_if.master fetch
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] pend_pc;
    logic        pend_valid;
    logic        req_q;
    logic        red_q;

    logic        sel_hit;
    logic [31:0] sel_pc;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic        take_exc;

    assign br_tgt = pc_d + 32'd4
                  + {{14{imm16_d[15]}}, imm16_d, 2'b00};
    assign j_tgt  = {pc_d[31:28], j_index, 2'b00};

`ifdef PC_REDIRECT_EXC_EN
    assign take_exc = exc_req;
`else
    logic unused_exc_vec;
    assign unused_exc_vec = ^EXC_VEC;
    assign take_exc = 1'b0;
`endif

    // Overlapping enables are illegal but still resolve by priority.
    always_comb begin
        sel_hit = 1'b1;
        sel_pc  = jr_target;
        if (jr_en) begin
            sel_pc = jr_target;
        end else if (j_en) begin
            sel_pc = j_tgt;
        end else if (br_en && br_taken) begin
            sel_pc = br_tgt;
        end else begin
            sel_hit = 1'b0;
            sel_pc  = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= BOOT;
            pc_q       <= RESET_PC;
            pend_pc    <= '0;
            pend_valid <= 1'b0;
            req_q      <= 1'b0;
            red_q      <= 1'b0;
        end else if (take_exc) begin
            state      <= RUN;
            pc_q       <= EXC_VEC;
            pend_valid <= 1'b0;
            req_q      <= 1'b1;
            red_q      <= 1'b1;
        end else begin
            red_q <= 1'b0;
            unique case (state)
                BOOT: begin
                    state <= RUN;
                    req_q <= 1'b1;
                end
                RUN: begin
                    if (fetch.if_ready) begin
                        // A stalled D re-presents its redirect next cycle.
                        if (!stall) begin
                            pc_q  <= sel_pc;
                            red_q <= sel_hit;
                        end
                    end else if (sel_hit) begin
                        pend_pc    <= sel_pc;
                        pend_valid <= 1'b1;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (fetch.if_ready && !stall && pend_valid) begin
                        pc_q       <= pend_pc;
                        pend_valid <= 1'b0;
                        red_q      <= 1'b1;
                        state      <= RUN;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

    assign fetch.pc_f     = pc_q;
    assign fetch.pc8_f    = pc_q + 32'd8;
    assign fetch.if_req   = req_q;
    assign fetch.redirect = red_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed plan plus random traffic checked
// every cycle against a behavioural fetch-PC model.
module tb_pc_redirect_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        br_en;
    logic        br_taken;
    logic [31:0] pc_d;
    logic [15:0] imm16_d;
    logic        j_en;
    logic [25:0] j_index;
    logic        jr_en;
    logic [31:0] jr_target;
    logic        exc_req;

    int total  = 0;
    int passed = 0;

    pc_redirect_unit_if fif ();

    pc_redirect_unit dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .br_en     (br_en),
        .br_taken  (br_taken),
        .pc_d      (pc_d),
        .imm16_d   (imm16_d),
        .j_en      (j_en),
        .j_index   (j_index),
        .jr_en     (jr_en),
        .jr_target (jr_target),
`ifdef PC_REDIRECT_EXC_EN
        .exc_req   (exc_req),
`endif
        .fetch     (fif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // Model: fetch address, pending target, boot flag; redirect
    // means "the PC was loaded from a target at the last edge".
    logic [31:0] m_pc, m_ppc, m_tgt;
    logic        m_req, m_red, m_boot, m_pend, m_hit, m_exc;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pc = 32'h0000_3000; m_ppc = '0;
            m_req = 0; m_red = 0; m_boot = 1; m_pend = 0;
        end else begin
`ifdef PC_REDIRECT_EXC_EN
            m_exc = exc_req;
`else
            m_exc = 1'b0;
`endif
            m_hit = 1'b1;
            if (jr_en) m_tgt = jr_target;
            else if (j_en)
                m_tgt = (pc_d & 32'hF000_0000) | (32'(j_index) << 2);
            else if (br_en && br_taken)
                m_tgt = pc_d + 32'd4 + 32'($signed(imm16_d)) * 32'd4;
            else begin
                m_hit = 1'b0;
                m_tgt = m_pc + 32'd4;
            end
            m_red = 1'b0;
            if (m_exc) begin
                m_pc = 32'h0000_4180; m_pend = 0;
                m_boot = 0; m_req = 1; m_red = 1;
            end else if (m_boot) begin
                m_boot = 0; m_req = 1;
            end else if (m_pend) begin
                if (fif.if_ready && !stall) begin
                    m_pc = m_ppc; m_pend = 0; m_red = 1;
                end
            end else if (!fif.if_ready) begin
                if (m_hit) begin m_pend = 1; m_ppc = m_tgt; end
            end else if (!stall) begin
                m_pc = m_tgt; m_red = m_hit;
            end
        end
    end

    always @(negedge clk) begin
        chk("pc_f", fif.pc_f, m_pc);
        chk("pc8_f", fif.pc8_f, m_pc + 32'd8);
        chk("if_req", {31'd0, fif.if_req}, {31'd0, m_req});
        chk("redirect", {31'd0, fif.redirect}, {31'd0, m_red});
    end

    task automatic clr();
        stall = 0; br_en = 0; br_taken = 0; j_en = 0; jr_en = 0;
        exc_req = 0;
    endtask

    task automatic lit(input string nm, input logic [31:0] pc,
                       input logic red);
        chk(nm, fif.pc_f, pc);
        chk({nm, "_red"}, {31'd0, fif.redirect}, {31'd0, red});
    endtask

    initial begin
        reset = 0; clr(); fif.if_ready = 1;
        pc_d = '0; imm16_d = '0; j_index = '0; jr_target = '0;
        @(negedge clk);
        lit("rst_pc", 32'h3000, 0);
        chk("rst_req", {31'd0, fif.if_req}, 32'd0);
        #1 reset = 1;
        @(negedge clk);
        lit("boot_pc", 32'h3000, 0);
        chk("run_req", {31'd0, fif.if_req}, 32'd1);
        #1; @(negedge clk); lit("seq4", 32'h3004, 0);
        #1; @(negedge clk); lit("seq8", 32'h3008, 0);
        #1 br_en = 1; br_taken = 1; pc_d = 32'h3008; imm16_d = 16'hFFFE;
        @(negedge clk); lit("br_back", 32'h3004, 1);
        #1 br_taken = 0;
        @(negedge clk); lit("br_not", 32'h3008, 0);
        #1 clr(); j_en = 1; pc_d = 32'h3010; j_index = 26'h0000C40;
        @(negedge clk); lit("jump", 32'h3100, 1);
        #1 jr_en = 1; jr_target = 32'h3200;
        @(negedge clk); lit("jr_wins", 32'h3200, 1);
        #1 clr();
        @(negedge clk); lit("after_jr", 32'h3204, 0);
        #1 br_en = 1; br_taken = 1; pc_d = 32'h3200; imm16_d = 16'hFF8F;
        fif.if_ready = 0;
        @(negedge clk); lit("wait0", 32'h3204, 0);
        #1 clr();
        @(negedge clk); lit("wait1", 32'h3204, 0);
        #1; @(negedge clk); lit("wait2", 32'h3204, 0);
        #1 fif.if_ready = 1;
        @(negedge clk); lit("pend_ld", 32'h3040, 1);
        #1; @(negedge clk); lit("pend_nx", 32'h3044, 0);
        #1 stall = 1; br_en = 1; br_taken = 1;
        pc_d = 32'h3044; imm16_d = 16'h0010;
        @(negedge clk); lit("stall0", 32'h3044, 0);
        #1; @(negedge clk); lit("stall1", 32'h3044, 0);
        #1 stall = 0;
        @(negedge clk); lit("stall_ld", 32'h3088, 1);
        #1 clr();
        @(negedge clk); lit("stall_nx", 32'h308C, 0);
        #1 jr_en = 1; jr_target = 32'hFFFF_FFFC;
        @(negedge clk); lit("top", 32'hFFFF_FFFC, 1);
        chk("pc8_wrap", fif.pc8_f, 32'h0000_0004);
        #1 clr();
        @(negedge clk); lit("wrap", 32'h0, 0);
        #1 jr_en = 1; jr_target = 32'h5000; fif.if_ready = 0;
        @(negedge clk); lit("wait_r", 32'h0, 0);
        #1 clr(); reset = 0;
        @(negedge clk); lit("rst_wait", 32'h3000, 0);
        #1 reset = 1; fif.if_ready = 1;
        @(negedge clk); lit("reboot", 32'h3000, 0);
        #1; @(negedge clk); lit("no_pend", 32'h3004, 0);
`ifdef PC_REDIRECT_EXC_EN
        #1 jr_en = 1; jr_target = 32'h6000; fif.if_ready = 0;
        @(negedge clk); lit("exc_w", 32'h3004, 0);
        #1 clr(); exc_req = 1; stall = 1;
        @(negedge clk); lit("exc_ld", 32'h4180, 1);
        #1 clr(); fif.if_ready = 1;
        @(negedge clk); lit("exc_nx", 32'h4184, 0);
`endif
        for (int i = 0; i < 3000; i++) begin
            int k;
            #1;
            clr();
            reset = ($urandom_range(0, 199) != 0);
            stall = ($urandom_range(0, 99) < 15);
            fif.if_ready = ($urandom_range(0, 99) < 70);
            pc_d = $urandom; imm16_d = 16'($urandom);
            j_index = 26'($urandom); jr_target = $urandom;
            br_taken = 1'($urandom);
            k = $urandom_range(0, 9);
            if (k <= 1) br_en = 1;
            else if (k == 2) j_en = 1;
            else if (k == 3) jr_en = 1;
            else if (k == 4) begin
                br_en = 1'($urandom); j_en = 1'($urandom);
                jr_en = 1'($urandom);
            end
`ifdef PC_REDIRECT_EXC_EN
            exc_req = ($urandom_range(0, 99) < 3);
`endif
            @(negedge clk);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
